reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port register file for the pipelined datapath. It has NRD read ports and two write ports (ALU writeback and load/JAL writeback). Write-through bypass is configurable, and a per-register busy scoreboard lets the decode stage detect read-after-write hazards and raise a stall. Register 0 reads as zero; register LINK_REG holds the JAL return address and is never bypassed.

Parameters:
DSIZE, 16, data width in bits
RSIZE, 4, address width; depth = 2**RSIZE registers
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return array contents only
LINK_REG, 15, index of the JAL return-address register; excluded from bypass

Ports:
Clock  in  1  system clock, all state updates on rising edge
Reset  in  1  asynchronous active-low reset
Wen1  in  1  write enable, port 1 (ALU writeback)
WAddr1  in  RSIZE  write address, port 1
WData1  in  DSIZE  write data, port 1
Wen2  in  1  write enable, port 2 (load/JAL writeback, higher priority)
WAddr2  in  RSIZE  write address, port 2
WData2  in  DSIZE  write data, port 2
RAddr  in  NRD*RSIZE  packed read addresses; port k = bits [k*RSIZE +: RSIZE]
RData  out  NRD*DSIZE  packed read data; port k = bits [k*DSIZE +: DSIZE]
Iss_En  in  1  issue: mark Iss_Addr busy (pending producer)
Iss_Addr  in  RSIZE  destination register of the issuing instruction
RBusy  out  NRD  per read port: source register has an unresolved pending write
Stall  out  1  OR of RBusy

Behaviour:
- Reset low (async, any time including mid-write): all 2**RSIZE registers <= 0, all busy bits <= 0. Outputs are combinational, so RData = 0, RBusy = 0 and Stall = 0 while Reset is low. Reset deassertion is assumed synchronous to Clock externally.
- Write: on posedge with Reset high, if WenN && WAddrN != 0 then reg[WAddrN] <= WDataN.
  - Both ports enabled to the same nonzero address: port 2 wins and port 1 is dropped.
  - Writes to address 0 are ignored; reg 0 is constant 0.
- Read, combinational and zero latency, per port k with a = RAddr_k:
  - a == 0 -> 0.
  - Else if BYPASS && Wen2 && WAddr2 == a && a != LINK_REG -> WData2.
  - Else if BYPASS && Wen1 && WAddr1 == a && a != LINK_REG -> WData1.
  - Else -> reg[a].
  - Bypass requires Wen. A matching address with Wen low never forwards.
- LINK_REG reads always return array contents: a JAL write is visible the cycle after it.
- Scoreboard: busy[2**RSIZE], one bit per register.
  - On posedge: busy[WAddrN] <= 0 for each enabled write port with nonzero address.
  - Then, if Iss_En && Iss_Addr != 0, busy[Iss_Addr] <= 1.
  - Set and clear of the same register in one cycle: set wins, because the newer producer owns it.
  - busy[0] is always 0.
- RBusy[k] = busy[a] && !hit_k, where hit_k = a bypass forward occurred on port k this cycle. If BYPASS=0, hit_k = 0, so a register being written this cycle still reports busy until the next cycle.
- Stall = |RBusy. Nothing sequential depends on Stall; it is advisory to the pipeline control.
- Iss_En to an already-busy register keeps it busy. There is no count; a single outstanding producer per register is required.
- Implementation estimate: about 150-250 lines (array, scoreboard, NRD generate loop for read muxes).

Test Plan:
- Reset mid-stream: write 0x1234 to r3, assert Reset low between edges -> RData for r3 = 0 immediately, RBusy = 0, array cleared; after release, read r3 -> 0.
- Bypass (BYPASS=1): Wen1=1, WAddr1=5, WData1=0xBEEF, RAddr port0=5 -> RData port0 = 0xBEEF in the same cycle. Same with Wen1=0 -> old r5 value (0).
- Write conflict: Wen1=Wen2=1, both addr 7, WData1=0x1111, WData2=0x2222 -> same-cycle bypass 0x2222; after the edge r7 = 0x2222.
- Register 0 and link register: write 0xFFFF to r0 -> reads 0. Wen2 to r15 with 0xA5A5 -> same-cycle read returns old r15 (0), next cycle 0xA5A5.
- Scoreboard: Iss_En with Iss_Addr=4, then read r4 -> RBusy=1, Stall=1. Next cycle Wen1 writes r4 = 0x0042 -> bypass gives 0x0042 and RBusy=0. Following cycle busy cleared.
- Set/clear collision: r6 busy; same cycle Wen2 writes r6 and Iss_En sets r6 -> after the edge r6 holds the new data and busy[6]=1, so Stall asserts on a read of r6 (BYPASS=0 and BYPASS=1 both checked).

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Register-file access bundle: two writeback ports, packed read ports and issue/hazard signals.
interface reg_file_mp_if #(
    parameter int DSIZE = 16,
    parameter int RSIZE = 4,
    parameter int NRD   = 2
);
    logic                   Wen1;
    logic [RSIZE-1:0]       WAddr1;
    logic [DSIZE-1:0]       WData1;
    logic                   Wen2;
    logic [RSIZE-1:0]       WAddr2;
    logic [DSIZE-1:0]       WData2;
    logic [NRD*RSIZE-1:0]   RAddr;
    logic [NRD*DSIZE-1:0]   RData;
    logic                   Iss_En;
    logic [RSIZE-1:0]       Iss_Addr;
    logic [NRD-1:0]         RBusy;
    logic                   Stall;

    modport master (
        output Wen1, WAddr1, WData1, Wen2, WAddr2, WData2, RAddr, Iss_En, Iss_Addr,
        input  RData, RBusy, Stall
    );

    modport slave (
        input  Wen1, WAddr1, WData1, Wen2, WAddr2, WData2, RAddr, Iss_En, Iss_Addr,
        output RData, RBusy, Stall
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with two writeback ports, optional write-through bypass
// and a per-register busy scoreboard for read-after-write hazard detection.
module reg_file_mp #(
    parameter int DSIZE    = 16,
    parameter int RSIZE    = 4,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int LINK_REG = 15
) (
    input  logic         Clock,
    input  logic         Reset,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** RSIZE;

    logic [DSIZE-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    logic             wr1_ok;
    logic             wr2_ok;
    logic [DSIZE-1:0] rd_data [NRD];
    logic [NRD-1:0]   rd_busy;

    assign wr2_ok = bus.Wen2 && (bus.WAddr2 != '0);
    // Port 2 (load/JAL) takes precedence when both target the same register.
    assign wr1_ok = bus.Wen1 && (bus.WAddr1 != '0) && !(wr2_ok && (bus.WAddr2 == bus.WAddr1));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr1_ok) regs[bus.WAddr1] <= bus.WData1;
            if (wr2_ok) regs[bus.WAddr2] <= bus.WData2;
        end
    end

    // Clear on writeback first, then set on issue so the newer producer keeps ownership.
    always_comb begin
        busy_nxt = busy;
        if (bus.Wen1 && (bus.WAddr1 != '0)) busy_nxt[bus.WAddr1] = 1'b0;
        if (wr2_ok) busy_nxt[bus.WAddr2] = 1'b0;
        if (bus.Iss_En && (bus.Iss_Addr != '0)) busy_nxt[bus.Iss_Addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RSIZE-1:0] a;
        logic [DSIZE-1:0] d;
        logic             hit;

        assign a = bus.RAddr[k*RSIZE +: RSIZE];

        // The link register is never forwarded: a JAL result appears the cycle after.
        always_comb begin
            hit = 1'b0;
            d   = regs[a];
            if (a == '0) begin
                d = '0;
            end else if ((BYPASS != 0) && bus.Wen2 && (bus.WAddr2 == a) && (a != RSIZE'(LINK_REG))) begin
                d   = bus.WData2;
                hit = 1'b1;
            end else if ((BYPASS != 0) && bus.Wen1 && (bus.WAddr1 == a) && (a != RSIZE'(LINK_REG))) begin
                d   = bus.WData1;
                hit = 1'b1;
            end
        end

        assign rd_data[k] = Reset ? d : '0;
        assign rd_busy[k] = Reset && busy[a] && !hit;
    end

    always_comb begin
        bus.RData = '0;
        for (int k = 0; k < NRD; k++) begin
            bus.RData[k*DSIZE +: DSIZE] = rd_data[k];
        end
    end

    assign bus.RBusy = rd_busy;
    assign bus.Stall = |rd_busy;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: BYPASS=1 and BYPASS=0 instances share stimulus,
// expectations are queued by the driver and checked by a negedge monitor.
module tb_reg_file_mp;
    logic Clock;
    logic Reset;

    logic        wen1, wen2, iss_en;
    logic [3:0]  waddr1, waddr2, iss_addr, ra0, ra1;
    logic [15:0] wdata1, wdata2;

    reg_file_mp_if #(.DSIZE(16), .RSIZE(4), .NRD(2)) if0 ();
    reg_file_mp_if #(.DSIZE(16), .RSIZE(4), .NRD(2)) if1 ();

    assign if0.Wen1 = wen1;   assign if1.Wen1 = wen1;
    assign if0.WAddr1 = waddr1; assign if1.WAddr1 = waddr1;
    assign if0.WData1 = wdata1; assign if1.WData1 = wdata1;
    assign if0.Wen2 = wen2;   assign if1.Wen2 = wen2;
    assign if0.WAddr2 = waddr2; assign if1.WAddr2 = waddr2;
    assign if0.WData2 = wdata2; assign if1.WData2 = wdata2;
    assign if0.RAddr = {ra1, ra0}; assign if1.RAddr = {ra1, ra0};
    assign if0.Iss_En = iss_en; assign if1.Iss_En = iss_en;
    assign if0.Iss_Addr = iss_addr; assign if1.Iss_Addr = iss_addr;

    reg_file_mp #(.DSIZE(16), .RSIZE(4), .NRD(2), .BYPASS(1), .LINK_REG(15)) dut_byp (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (if0)
    );

    reg_file_mp #(.DSIZE(16), .RSIZE(4), .NRD(2), .BYPASS(0), .LINK_REG(15)) dut_nobyp (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (if1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        int          dut;
        int          port;
        logic [15:0] d;
        logic        b;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Stall is expected to equal the checked port's busy bit: the other port never reads a busy register.
    task automatic expect_rd(input string name, input int port,
                             input logic [15:0] d_byp, input logic b_byp,
                             input logic [15:0] d_nob, input logic b_nob);
        exp_t e;
        e.name = name; e.port = port;
        e.dut = 0; e.d = d_byp; e.b = b_byp; q.push_back(e);
        e.dut = 1; e.d = d_nob; e.b = b_nob; q.push_back(e);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    always @(negedge Clock) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [15:0] ad;
            logic        ab, as;
            e = q.pop_front();
            if (e.dut == 0) begin
                ad = if0.RData[e.port*16 +: 16]; ab = if0.RBusy[e.port]; as = if0.Stall;
            end else begin
                ad = if1.RData[e.port*16 +: 16]; ab = if1.RBusy[e.port]; as = if1.Stall;
            end
            n_total++;
            if (ad === e.d && ab === e.b && as === e.b) begin
                n_pass++;
            end else begin
                $display("FAIL %s (bypass=%0d port=%0d): got data=%h busy=%b stall=%b, want data=%h busy=%b stall=%b",
                         e.name, (e.dut == 0), e.port, ad, ab, as, e.d, e.b, e.b);
            end
        end
    end

    initial begin
        Reset = 1'b0;
        wen1 = 0; wen2 = 0; iss_en = 0;
        waddr1 = 0; waddr2 = 0; iss_addr = 0; ra0 = 0; ra1 = 0;
        wdata1 = 0; wdata2 = 0;

        step();
        ra0 = 4'd3; ra1 = 4'd15;
        expect_rd("reset_p0", 0, 16'h0, 0, 16'h0, 0);
        expect_rd("reset_p1", 1, 16'h0, 0, 16'h0, 0);

        step();
        Reset = 1'b1; ra1 = 4'd0;
        wen1 = 1; waddr1 = 4'd3; wdata1 = 16'h1234;
        expect_rd("wr_r3_same", 0, 16'h1234, 0, 16'h0, 0);

        step();
        wen1 = 0; iss_en = 1; iss_addr = 4'd3;
        expect_rd("rd_r3", 0, 16'h1234, 0, 16'h1234, 0);

        // Reset pulled low between edges, with r3 written and marked busy.
        step();
        iss_en = 0; Reset = 1'b0;
        expect_rd("midrst_r3", 0, 16'h0, 0, 16'h0, 0);

        step();
        Reset = 1'b1;
        expect_rd("postrst_r3", 0, 16'h0, 0, 16'h0, 0);

        step();
        wen1 = 0; waddr1 = 4'd5; wdata1 = 16'hBEEF; ra0 = 4'd5;
        expect_rd("nobyp_wen0", 0, 16'h0, 0, 16'h0, 0);

        step();
        wen1 = 1;
        expect_rd("byp_r5", 0, 16'hBEEF, 0, 16'h0, 0);

        step();
        wen1 = 0;
        expect_rd("rd_r5", 0, 16'hBEEF, 0, 16'hBEEF, 0);

        step();
        wen1 = 1; waddr1 = 4'd7; wdata1 = 16'h1111;
        wen2 = 1; waddr2 = 4'd7; wdata2 = 16'h2222;
        ra0 = 4'd7; ra1 = 4'd7;
        expect_rd("conflict_p0", 0, 16'h2222, 0, 16'h0, 0);
        expect_rd("conflict_p1", 1, 16'h2222, 0, 16'h0, 0);

        step();
        wen1 = 0; wen2 = 0; ra1 = 4'd0;
        expect_rd("rd_r7", 0, 16'h2222, 0, 16'h2222, 0);

        step();
        wen1 = 1; waddr1 = 4'd0; wdata1 = 16'hFFFF;
        wen2 = 1; waddr2 = 4'd15; wdata2 = 16'hA5A5;
        ra0 = 4'd0; ra1 = 4'd15;
        expect_rd("r0_write", 0, 16'h0, 0, 16'h0, 0);
        expect_rd("link_same", 1, 16'h0, 0, 16'h0, 0);

        step();
        wen1 = 0; wen2 = 0;
        expect_rd("r0_after", 0, 16'h0, 0, 16'h0, 0);
        expect_rd("link_next", 1, 16'hA5A5, 0, 16'hA5A5, 0);

        step();
        ra1 = 4'd0; ra0 = 4'd4; iss_en = 1; iss_addr = 4'd4;
        expect_rd("issue_r4", 0, 16'h0, 0, 16'h0, 0);

        step();
        iss_en = 0;
        expect_rd("busy_r4", 0, 16'h0, 1, 16'h0, 1);

        step();
        wen1 = 1; waddr1 = 4'd4; wdata1 = 16'h0042;
        expect_rd("wb_r4", 0, 16'h0042, 0, 16'h0, 1);

        step();
        wen1 = 0;
        expect_rd("clr_r4", 0, 16'h0042, 0, 16'h0042, 0);

        step();
        ra0 = 4'd6; iss_en = 1; iss_addr = 4'd6;
        expect_rd("issue_r6", 0, 16'h0, 0, 16'h0, 0);

        step();
        wen2 = 1; waddr2 = 4'd6; wdata2 = 16'h7777;
        expect_rd("collide_r6", 0, 16'h7777, 0, 16'h0, 1);

        step();
        wen2 = 0; iss_en = 0;
        expect_rd("after_collide", 0, 16'h7777, 1, 16'h7777, 1);

        @(negedge Clock);
        #1;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
